// File: rtl/sm4_key_expand.sv
// sm4_key_expand: iterative SM4 key schedule. Accepts a 128-bit master key
// and streams round keys rk0..rk31, one per clock, with valid/index/done.
// Optional round-key store enabled by defining SM4_KEY_STORE_EN. With the
// store, rd_data returns store[rd_addr] one cycle later, and only after a
// complete schedule has been written.

// SM4 S-box: 8-bit substitution, purely combinational lookup.
module sm4_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Row-major table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry n starts at bit 8*(255-n), which is {~n, 3'b000}.
  assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];
endmodule

// SM4 CK constant table: byte j of CK[i] is (4*i + j) * 7 mod 256.
module sm4_ck (
  input  logic [4:0]  idx_i,
  output logic [31:0] ck_o
);
  // Build the four bytes of the selected constant.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    ck_o = '0;
    for (int j = 0; j < 4; j++) begin
      ck_o[8*(3-j) +: 8] = ({1'b0, idx_i, 2'b00} + 8'(j)) * 8'd7;
    end
  end
endmodule

module sm4_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  output logic [4:0]   rk_index,
  output logic [31:0]  rk_out,
  output logic         done,
  input  logic [4:0]   rd_addr,
  output logic [31:0]  rd_data
);
  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] k0_q, k1_q, k2_q, k3_q;
  logic        rk_valid_q, done_q;
  logic [4:0]  rk_index_q;
  logic [31:0] rk_out_q;

  logic [31:0] ck_w, x_d, b_d, t_d, rk_d;
  logic        accept_d, last_d;

  sm4_ck u_ck (
    .idx_i (cnt_q),
    .ck_o  (ck_w)
  );

  assign x_d = k1_q ^ k2_q ^ k3_q ^ ck_w;

  for (genvar g = 0; g < 4; g++) begin : g_tau
    sm4_sbox u_sbox (
      .in_i  (x_d[8*g +: 8]),
      .out_o (b_d[8*g +: 8])
    );
  end

  // Key-schedule linear transform: B ^ (B <<< 13) ^ (B <<< 23).
  assign t_d  = b_d ^ {b_d[18:0], b_d[31:19]} ^ {b_d[8:0], b_d[31:9]};
  assign rk_d = k0_q ^ t_d;

  assign key_ready = (state_q == IDLE);
  assign accept_d  = key_valid && key_ready;
  assign last_d    = (state_q == RUN) && (cnt_q == 5'd31);

  // Control FSM, key shift register and registered round-key outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      k0_q       <= '0;
      k1_q       <= '0;
      k2_q       <= '0;
      k3_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      rk_out_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rk_valid_q <= 1'b0;
          done_q     <= 1'b0;
          if (accept_d) begin
            k0_q    <= key_in[127:96] ^ FK0;
            k1_q    <= key_in[95:64]  ^ FK1;
            k2_q    <= key_in[63:32]  ^ FK2;
            k3_q    <= key_in[31:0]   ^ FK3;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          rk_out_q   <= rk_d;
          rk_index_q <= cnt_q;
          rk_valid_q <= 1'b1;
          k0_q       <= k1_q;
          k1_q       <= k2_q;
          k2_q       <= k3_q;
          k3_q       <= rk_d;
          cnt_q      <= cnt_q + 5'd1;
          done_q     <= last_d;
          if (last_d) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_index = rk_index_q;
  assign rk_out   = rk_out_q;
  assign done     = done_q;

`ifdef SM4_KEY_STORE_EN
  logic [31:0] store_q [32];
  logic        store_full_q;
  logic [31:0] rd_data_q;

  // Round-key store: capture each key at its round address.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; stale contents are masked by store_full_q.
    if (state_q == RUN) store_q[cnt_q] <= rk_d;
  end

  // Completion flag and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_full_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_data_q <= store_full_q ? store_q[rd_addr] : '0;
      if (accept_d)    store_full_q <= 1'b0;
      else if (last_d) store_full_q <= 1'b1;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif
endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: an independent key-schedule model
// fills a scoreboard queue when a key is driven; the stream is popped and
// compared as rk_valid appears. Also checks handshake timing, reset, the
// back-to-back gap, and the read store (SM4_KEY_STORE_EN) or its absence.
module tb_sm4_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic [4:0]   rk_index;
  logic [31:0]  rk_out;
  logic         done;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;

  always #5 clk = ~clk;

  sm4_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_index  (rk_index),
    .rk_out    (rk_out),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  localparam logic [127:0] TV_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] rk;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rk [32];
  logic [31:0] seen_rk  [32];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [7:0] sb(input logic [7:0] x);
    int p;
    p = 2047 - 8 * int'(x);
    return SBOX[p -: 8];
  endfunction

  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Model the whole schedule for mk and queue the 32 expected outputs.
  task automatic push_schedule(input logic [127:0] mk);
    logic [31:0] k0, k1, k2, k3, rk;
    exp_t        e;
    k0 = mk[127:96] ^ 32'hA3B1BAC6;
    k1 = mk[95:64]  ^ 32'h56AA3350;
    k2 = mk[63:32]  ^ 32'h677D9197;
    k3 = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      rk = k0 ^ t_prime(k1 ^ k2 ^ k3 ^ ck_word(i));
      model_rk[i] = rk;
      e = {5'(i), rk, (i == 31)};
      exp_q.push_back(e);
      k0 = k1; k1 = k2; k2 = k3; k3 = rk;
    end
  endtask

  // Wait to the middle of the next cycle and score any streamed round key.
  task automatic score_cycle();
    exp_t e;
    @(negedge clk);
    if (rk_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rk_stream: unexpected rk_valid idx=%0d rk=%08h, required no output", rk_index, rk_out);
      end else begin
        e = exp_q.pop_front();
        if ({rk_index, rk_out, done} !== e) begin
          n_err++;
          $display("FAIL rk_stream: got idx=%0d rk=%08h done=%0b, required idx=%0d rk=%08h done=%0b",
                   rk_index, rk_out, done, e.idx, e.rk, e.done);
        end
      end
      seen_rk[rk_index] = rk_out;
    end else begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_alone: got done=%0b with rk_valid=%0b, required 0", done, rk_valid);
      end
    end
  endtask

  // Drive one schedule from an idle cycle (or continue one already accepted)
  // and check per-cycle handshake timing relative to the acceptance edge.
  task automatic run_schedule(input logic [127:0] mk, input bit start, input bit garbage,
                              input bit chain, input logic [127:0] next_mk);
    int timing_bad;
    timing_bad = 0;
    for (int i = 0; i < 32; i++) seen_rk[i] = '0;
    if (start) begin
      key_in    = mk;
      key_valid = 1'b1;
      push_schedule(mk);
    end
    for (int k = 1; k <= 33; k++) begin
      score_cycle();
      if (key_ready !== (k == 33) || rk_valid !== (k >= 2)) begin
        timing_bad++;
        $display("FAIL handshake_timing: cycle E+%0d key_ready=%0b rk_valid=%0b, required %0b/%0b",
                 k, key_ready, rk_valid, (k == 33), (k >= 2));
      end
      if (k == 3) begin
        n_cmp++;
        if (rd_data !== 32'h0) begin
          n_err++;
          $display("FAIL rd_data_before_done: got %08h, required 00000000", rd_data);
        end
      end
      if (k <= 32) begin
        key_valid = garbage;
        if (garbage) key_in = {$urandom, $urandom, $urandom, $urandom};
      end else if (chain) begin
        key_in    = next_mk;
        key_valid = 1'b1;
        push_schedule(next_mk);
      end else begin
        key_valid = 1'b0;
      end
    end
    n_cmp++;
    if (timing_bad != 0) begin
      n_err++;
      $display("FAIL handshake_summary: got %0d bad cycles, required 0", timing_bad);
    end
  endtask

  // After a schedule: stream stops and the scoreboard is empty.
  task automatic check_idle_after(input string tag);
    score_cycle();
    n_cmp++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_idle: got rk_valid=%0b key_ready=%0b pending=%0d, required 0/1/0",
               tag, rk_valid, key_ready, exp_q.size());
    end
  endtask

  // Compare captured round keys with the published test-vector values.
  task automatic check_vectors(input string tag);
    int          idx_l [5] = '{0, 1, 2, 3, 31};
    logic [31:0] val_l [5] = '{32'hF12186F9, 32'h41662B61, 32'h5A6AB19A, 32'h7BA92077, 32'h9124A012};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (seen_rk[idx_l[i]] !== val_l[i]) begin
        n_err++;
        $display("FAIL %s_rk%0d: got %08h, required %08h", tag, idx_l[i], seen_rk[idx_l[i]], val_l[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rk_valid, rk_index, rk_out, done, key_ready, rd_data} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b idx=%0d rk=%08h done=%0b rdy=%0b rd=%08h, required 0/0/0/0/1/0",
               rk_valid, rk_index, rk_out, done, key_ready, rd_data);
    end
    rst_n = 1'b1;
    score_cycle();
  endtask

  task automatic test_basic();
    run_schedule(TV_KEY, 1'b1, 1'b0, 1'b0, '0);
    check_vectors("basic");
    check_idle_after("basic");
  endtask

  task automatic test_store();
    int a_l [4] = '{0, 31, 5, 17};
    logic [31:0] req;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 5'(a_l[i]);
      score_cycle();
`ifdef SM4_KEY_STORE_EN
      req = (a_l[i] == 0) ? 32'hF12186F9 : (a_l[i] == 31) ? 32'h9124A012 : model_rk[a_l[i]];
`else
      req = 32'h0;
`endif
      n_cmp++;
      if (rd_data !== req) begin
        n_err++;
        $display("FAIL store_read[%0d]: got %08h, required %08h", a_l[i], rd_data, req);
      end
    end
    rd_addr = 5'd0;
  endtask

  task automatic test_ignore_during_run();
    run_schedule(TV_KEY, 1'b1, 1'b1, 1'b0, '0);
    check_vectors("ignore");
    check_idle_after("ignore");
  endtask

  task automatic test_back_to_back();
    run_schedule(TV_KEY, 1'b1, 1'b0, 1'b1, '0);
    run_schedule('0, 1'b0, 1'b0, 1'b0, '0);
    check_idle_after("b2b");
  endtask

  task automatic test_reset_mid_run();
    int late;
    key_in    = TV_KEY;
    key_valid = 1'b1;
    push_schedule(TV_KEY);
    for (int k = 1; k <= 12; k++) begin
      score_cycle();
      key_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    n_cmp++;
    if (rk_valid !== 1'b0 || done !== 1'b0 || key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got rk_valid=%0b done=%0b key_ready=%0b, required 0/0/1", rk_valid, done, key_ready);
    end
    rst_n = 1'b1;
    late = 0;
    repeat (4) begin
      @(negedge clk);
      if (rk_valid !== 1'b0) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: got %0d rk_valid cycles after reset, required 0", late);
    end
    run_schedule({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, '0);
    check_idle_after("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_store();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sm4_key_expand.md
Name: sm4_key_expand

Overview:
Iterative SM4 key-schedule generator, directly upstream of the SM4 round datapath.
- Accepts a 128-bit master key MK.
- Produces the 32 round keys rk0..rk31, one per clock, as a valid-qualified stream.
- Instantiates the team's SM4 S-box module four times (tau transform) and the CK constant table once (indexed by round counter).

Parameters:
- None. Rounds fixed at 32. FK fixed: FK0=A3B1BAC6, FK1=56AA3350, FK2=677D9197, FK3=B27022DC.

Ports:
- clk       input   1    single clock; all state on rising edge
- rst_n     input   1    reset; synchronous, active-low
- key_valid input   1    MK presented
- key_ready output  1    block idle, will accept MK
- key_in    input   128  MK; MK0 = key_in[127:96] .. MK3 = key_in[31:0]
- rk_valid  output  1    rk_out/rk_index valid this cycle
- rk_index  output  5    round number i of rk_out
- rk_out    output  32   round key rk_i
- done      output  1    one-cycle pulse with rk31
- rd_addr   input   5    store read address (optional feature)
- rd_data   output  32   store read data (optional feature)

Behaviour:
- Reset (rst_n=0 sampled at an edge): state=IDLE, cnt=0, K0..K3=0, rk_valid=0, rk_index=0, rk_out=0, done=0, key_ready=1, rd_data=0.
- Reset mid-RUN aborts the schedule; no further rk_valid is issued.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: Kj <= MKj ^ FKj (j=0..3), cnt <= 0, go to RUN.
- RUN:
  - key_ready=0; key_valid ignored.
  - Each cycle, combinationally:
    - X = K1^K2^K3^CK[cnt]
    - B = Sbox on each of the 4 bytes of X
    - T' = B ^ (B<<<13) ^ (B<<<23)
    - rk = K0 ^ T'
  - At the edge:
    - rk_out <= rk, rk_index <= cnt, rk_valid <= 1.
    - Shift: K0<=K1, K1<=K2, K2<=K3, K3<=rk.
    - cnt <= cnt+1.
  - When cnt==31: additionally done <= 1, state <= IDLE.
- Latency: MK accepted at edge E gives rk_i valid in cycle E+2+i (i=0..31). Exactly 32 consecutive rk_valid cycles, no gaps.
- No backpressure: the consumer must sample every rk_valid cycle.
- rk_valid and done drop to 0 the cycle after rk31.
- key_ready returns to 1 in the same cycle done=1. A key accepted in that cycle starts the next schedule back-to-back, giving a one-cycle rk_valid gap.
- All XOR/rotate are 32-bit modulo; cnt is 5 bits and wraps 31->0 only on exit.

Optional Feature:
- Macro: SM4_KEY_STORE_EN.
- Defined:
  - 32x32 store written with rk_out at each RUN edge, at address cnt.
  - rd_data <= store[rd_addr] registered; 1-cycle read latency.
  - A store-complete flag is set on done and cleared on reset and on key acceptance. While the flag is clear, rd_data reads 0.
  - Decrypt consumers read addresses 31..0.
- Undefined:
  - No storage; rd_addr ignored; rd_data constant 0.

Test Plan:
- Reset, then key_in=0123456789ABCDEFFEDCBA9876543210, key_valid=1 one cycle -> 32 consecutive rk_valid cycles: rk0=F12186F9, rk1=41662B61, rk2=5A6AB19A, rk3=7BA92077, rk31=9124A012 with rk_index 0..31; done=1 only with rk31.
- Latency: accept at edge E -> rk_valid first high in cycle E+2; key_ready=0 for cycles E+1..E+32, high again in cycle E+33 (the done cycle).
- key_valid held high with changing key_in during RUN -> ignored; outputs match the first-key vectors exactly.
- Back-to-back: second key (all-zero MK) presented in the done cycle -> accepted; one-cycle rk_valid gap, then 32 new keys starting with rk_index=0.
- rst_n=0 for one cycle at round 10 -> next cycle rk_valid=0, done=0, key_ready=1; a new key gives the correct full schedule from rk0.
- SM4_KEY_STORE_EN defined, after test-1 done: rd_addr=0 -> rd_data=F12186F9 next cycle; rd_addr=31 -> 9124A012. Before done, or after a new key is accepted -> 0.
